spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
// - SPI peripheral (slave) end of the link driven by our SPI master: full-duplex, MSB first, 8-bit frames.
// - Oversamples SPI clock, CS_n and MOSI in the i_clk domain and deserialises MOSI into o_RX_Byte.
// - Serialises a host-loaded byte onto MISO; back-to-back bytes are allowed while CS_n stays low.
// PARAMETERS
// - SPI_MODE    0      CPOL/CPHA: 0=00, 1=01, 2=10, 3=11. Must match the master.
// - TX_DEFAULT  8'hFF  byte shifted out when no host byte is pending at a byte boundary.
// PORTS
// - i_clk           in   1  system clock; must be >= 8x the SPI clock rate.
// - i_rst           in   1  synchronous, active-high reset.
// - i_TX_Byte       in   8  byte to return to the master.
// - i_TX_DV         in   1  1-cycle load strobe for i_TX_Byte; accepted only while o_TX_Ready=1.
// - o_TX_Ready      out  1  holding register is empty.
// - o_RX_DV         out  1  1-cycle pulse: o_RX_Byte is valid.
// - o_RX_Byte       out  8  last complete received byte; held until the next byte completes.
// - o_TX_Underrun   out  1  1-cycle pulse: TX_DEFAULT was used (only with the macro; else tied 0).
// - i_SPI_clk       in   1  SPI clock from the master (asynchronous).
// - i_SPI_CS_n      in   1  chip select, active low (asynchronous).
// - i_SPI_MOSI      in   1  serial data from the master (asynchronous).
// - o_SPI_MISO      out  1  serial data to the master.
// - o_SPI_MISO_En   out  1  MISO output enable for the top-level tristate; 1 while CS_n is low.
// BEHAVIOUR
// - Reset values:
//   - o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=8'h00, o_TX_Underrun=0, o_SPI_MISO=0, o_SPI_MISO_En=0.
//   - Holding register empty, bit counter=7.
//   - Synchroniser flops preset to clk=CPOL, CS_n=1, MOSI=0.
// - Synchronisers and edge detection:
//   - Each of clk, CS_n and MOSI passes through 2 flops, then one delay flop.
//   - Edge strobes (leading/trailing SPI edge, CS fall, CS rise) are 1-cycle pulses, 3 i_clk after the pin change.
//   - Leading edge = transition away from CPOL.
// - Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
// - States: IDLE (CS high), ACTIVE (CS low). CS fall -> ACTIVE; CS rise -> IDLE.
// - Transmit load:
//   - The shift register loads at each byte boundary and drives its MSB on o_SPI_MISO in the same cycle.
//   - CPHA=0 boundaries: the CS fall strobe, and the shift edge after the 8th sample edge.
//   - CPHA=1 boundary: the first shift edge of each byte.
//   - Load source: holding register if full (holding becomes empty, o_TX_Ready rises the next cycle).
//   - Otherwise i_TX_Byte if i_TX_DV is high in that same cycle (bypass; counts as a valid load).
//   - Otherwise TX_DEFAULT.
// - Shift edges that are not boundaries put the next bit, MSB to LSB, on o_SPI_MISO.
// - Receive:
//   - On each sample edge, the synchronised MOSI goes into rx_shift[bit_cnt] and bit_cnt decrements (7->0, wraps).
//   - On the 8th sample edge, o_RX_Byte is updated and o_RX_DV pulses on the next cycle.
//   - Latency is 4 i_clk from the 8th sampling pin edge to o_RX_DV.
// - Host handshake:
//   - i_TX_DV while o_TX_Ready=1 stores the byte and drops o_TX_Ready the next cycle.
//   - i_TX_DV while o_TX_Ready=0 is ignored; the held byte is kept.
// - CS rise mid-byte:
//   - Partial byte discarded, no o_RX_DV, bit_cnt set to 7.
//   - o_SPI_MISO_En drops on the CS rise strobe cycle; the holding register is untouched.
// - CS rise coinciding with the 8th sample edge: the byte completes and o_RX_DV still pulses.
// - SPI edges while CS_n is high are ignored.
// - i_rst asserted mid-frame returns everything to reset values on the next edge.
// - A re-asserted CS_n then starts a fresh frame.
// CONFIGURATION
// - SPI_SLAVE_UNDERRUN_EN defined:
//   - o_TX_Underrun pulses 1 cycle in the boundary cycle where TX_DEFAULT is loaded.
//   - Bypass loads do not count as underrun.
// - SPI_SLAVE_UNDERRUN_EN undefined: o_TX_Underrun is constant 0 and the detection logic is not built.
// - Data path is identical in both cases.
// TESTING
// - Mode 0, SPI clk=i_clk/8:
//   - Host loads 8'hA5, master sends 8'h3C.
//   - Expect MISO bits 1,0,1,0,0,1,0,1 and o_RX_Byte=8'h3C with a 1-cycle o_RX_DV.
//   - Expect o_TX_Ready 0 then 1 after the load.
// - Modes 1, 2 and 3: master sends 8'hC3, slave returns 8'h5A.
//   - Both bytes must match exactly, and o_RX_DV must arrive 4 i_clk after the 8th sampling edge.
// - Back-to-back in one CS low, host loading 8'h11 then 8'h22 in time:
//   - RX pulses twice and MISO carries 8'h11, 8'h22.
// - Underrun: no host byte for the 2nd byte.
//   - MISO carries 8'hFF; o_TX_Underrun pulses once with the macro, stays 0 without it.
// - CS_n raised after 4 bits:
//   - No o_RX_DV, o_SPI_MISO_En=0.
//   - The next full frame 8'h81 is received correctly.
// - i_rst pulsed mid-byte: all outputs return to reset values; the following 8'h7E frame is received correctly.
// - i_TX_DV while o_TX_Ready=0: the extra byte is ignored and the earlier byte is transmitted.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral (mode SPI_MODE), 8-bit MSB-first full duplex; o_TX_Underrun built only with SPI_SLAVE_UNDERRUN_EN.
// Latency: o_RX_DV 4 i_clk after the 8th sampling pin edge; backpressure: i_TX_DV ignored while o_TX_Ready=0.
module spi_slave #(
    parameter int         SPI_MODE   = 0,
    parameter logic [7:0] TX_DEFAULT = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_TX_Underrun,
    input  logic       i_SPI_clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);
    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state_q, state_d;

    logic [2:0] sclk_q, cs_q, mosi_q;
    logic       lead_edge, trail_edge, cs_fall, cs_rise, mosi_s;
    logic       sample_edge, shift_edge, boundary;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_done_q, rx_done_d;
    logic       rx_dv_q;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] load_byte;

    // [0],[1] synchronise, [2] is the delay flop used for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_q <= {3{CPOL}};
            cs_q   <= 3'b111;
            mosi_q <= 3'b000;
        end else begin
            sclk_q <= {sclk_q[1:0], i_SPI_clk};
            cs_q   <= {cs_q[1:0], i_SPI_CS_n};
            mosi_q <= {mosi_q[1:0], i_SPI_MOSI};
        end
    end

    assign lead_edge  = (sclk_q[1] != CPOL) && (sclk_q[2] == CPOL);
    assign trail_edge = (sclk_q[1] == CPOL) && (sclk_q[2] != CPOL);
    assign cs_fall    = !cs_q[1] && cs_q[2];
    assign cs_rise    = cs_q[1] && !cs_q[2];
    assign mosi_s     = mosi_q[2];

    assign sample_edge = (state_q == ACTIVE) && (CPHA ? trail_edge : lead_edge);
    assign shift_edge  = (state_q == ACTIVE) && (CPHA ? lead_edge : trail_edge);
    assign boundary    = (shift_edge && (bit_cnt_q == 3'd7)) || (!CPHA && cs_fall);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_SPI_MISO_En = 1'b0;
        if ((state_q == ACTIVE) && !cs_rise) o_SPI_MISO_En = 1'b1;
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_done_d   = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (hold_full_q)  load_byte = hold_q;
        else if (i_TX_DV) load_byte = i_TX_Byte;
        else              load_byte = TX_DEFAULT;

        if (sample_edge) begin
            rx_shift_d[bit_cnt_q] = mosi_s;
            bit_cnt_d             = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
                rx_byte_d = {rx_shift_q[7:1], mosi_s};
                rx_done_d = 1'b1;
            end
        end
        // a CS change always restarts the byte, even if the 8th sample lands in the same cycle
        if (cs_fall || cs_rise) bit_cnt_d = 3'd7;

        if (boundary) begin
            tx_shift_d  = load_byte;
            hold_full_d = 1'b0;
        end else if (shift_edge) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        // at a boundary with an empty holding register the strobe is a bypass load, not a store
        if (i_TX_DV && !hold_full_q && !boundary) begin
            hold_d      = i_TX_Byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt_q   <= 3'd7;
            rx_shift_q  <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_done_q   <= 1'b0;
            rx_dv_q     <= 1'b0;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_done_q   <= rx_done_d;
            rx_dv_q     <= rx_done_q;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q, underrun_d;
    assign underrun_d = boundary && !hold_full_q && !i_TX_DV;
    always_ff @(posedge i_clk) begin
        if (i_rst) underrun_q <= 1'b0;
        else       underrun_q <= underrun_d;
    end
    assign o_TX_Underrun = underrun_q;
`else
    assign o_TX_Underrun = 1'b0;
`endif

    assign o_TX_Ready = !hold_full_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_MISO = tx_shift_q[7];

endmodule
